// File: rtl/gticc_qpll_reset_seq.sv
// Reset/lock sequencer for the GTX quad PLL common block.
// Drives the QPLL reset and synchronises its resetdone. It qualifies lock
// stability before raising pll_ready, and retries with a bounded budget
// before it parks in FAULT.
module gticc_qpll_reset_seq #(
  parameter int unsigned INIT_WAIT_CYCLES    = 500,
  parameter int unsigned RESET_PULSE_CYCLES  = 64,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 100000,
  parameter int unsigned STABLE_CYCLES       = 1024,
  parameter int unsigned MAX_RETRY           = 15,
  parameter int unsigned CNT_W               = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       qpll_resetdone,
  output logic       qpll_reset,
  output logic       pll_ready,
  output logic       lost_lock,
  output logic       fault,
  output logic [3:0] retry_count,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_INIT_WAIT  = 3'd0,
    S_ASSERT_RST = 3'd1,
    S_WAIT_LOCK  = 3'd2,
    S_STABLE     = 3'd3,
    S_READY      = 3'd4,
    S_FAULT      = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] INIT_LAST    = CNT_W'(INIT_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RESET_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRY);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [3:0]         retry_q, retry_d;
  logic               fault_q, fault_d;
  logic               ready_q, ready_d;
  logic               lost_q, lost_d;
  logic               qrst_q, qrst_d;
  logic               sync1_q, lock_sync_q;
  logic               do_retry;

  // Two-flop synchroniser bringing qpll_resetdone into the clk domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      sync1_q     <= qpll_resetdone;
      lock_sync_q <= sync1_q;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_INIT_WAIT;
      cnt_q   <= '0;
      retry_q <= '0;
      fault_q <= 1'b0;
      ready_q <= 1'b0;
      lost_q  <= 1'b0;
      qrst_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      fault_q <= fault_d;
      ready_q <= ready_d;
      lost_q  <= lost_d;
      qrst_q  <= qrst_d;
    end
  end

  // Next-state logic; outputs are derived from the next state so that they
  // change on the same edge as the state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    retry_d  = retry_q;
    fault_d  = fault_q;
    ready_d  = ready_q;
    lost_d   = 1'b0;
    do_retry = 1'b0;
    cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;

    case (state_q)
      S_INIT_WAIT: begin
        if (cnt_q == INIT_LAST) begin
          state_d = S_ASSERT_RST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_ASSERT_RST: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WAIT_LOCK: begin
        if (lock_sync_q) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          do_retry = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_STABLE: begin
        if (!lock_sync_q) begin
          do_retry = 1'b1;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = S_READY;
          ready_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_READY: begin
        if (!lock_sync_q) begin
          state_d = S_ASSERT_RST;
          ready_d = 1'b0;
          lost_d  = 1'b1;
          retry_d = '0;
          cnt_d   = '0;
        end
      end
      S_FAULT: begin
        fault_d = 1'b1;
      end
      default: begin
        state_d = S_INIT_WAIT;
        cnt_d   = '0;
      end
    endcase

    // Shared retry path for lock timeout and loss of lock during STABLE.
    if (do_retry) begin
      cnt_d = '0;
      if (retry_q >= RETRY_MAX) begin
        state_d = S_FAULT;
        fault_d = 1'b1;
      end else begin
        state_d = S_ASSERT_RST;
        retry_d = retry_q + 4'd1;
      end
    end

    // A soft restart overrides every other transition.
    if (start) begin
      state_d = S_ASSERT_RST;
      cnt_d   = '0;
      retry_d = '0;
      fault_d = 1'b0;
      ready_d = 1'b0;
      lost_d  = 1'b0;
    end

    qrst_d = (state_d == S_INIT_WAIT) || (state_d == S_ASSERT_RST) ||
             (state_d == S_FAULT);
  end

  assign qpll_reset  = qrst_q;
  assign pll_ready   = ready_q;
  assign lost_lock   = lost_q;
  assign fault       = fault_q;
  assign retry_count = retry_q;
  assign state_o     = state_q;

endmodule
